// File: rtl/icache_refill_pkg.sv
// ---------------------------------------------------------------------------
// icache_refill_pkg
// Shared definitions for the instruction-cache refill path: refill FSM state
// encoding, the address-split widths also used by the icache tag array, and
// the memory read-response code that means "no error".
// ---------------------------------------------------------------------------
package icache_refill_pkg;

  localparam int OFFSET_W = 3;
  localparam int INDEX_W  = 6;
  localparam int TAG_W    = 64 - INDEX_W - OFFSET_W;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RECV = 3'd2,
    S_FILL = 3'd3,
    S_WAIT = 3'd4
  } refill_state_e;

endpackage

// File: rtl/icache_line_buf.sv
// ---------------------------------------------------------------------------
// icache_line_buf
// Collects read beats of one burst into a cache line and tracks whether the
// burst went wrong (bad response / misplaced rlast) or was flushed.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_clear           start of a new burst: zero counter and flags
//   i_accept          a beat is accepted this cycle
//   i_flush           flush seen during the burst (sticky drop)
//   i_rdata/rresp/rlast  beat payload
//   o_line            assembled line
//   o_last            the accepted beat ends the burst
//   o_err, o_drop     flags including the current cycle's contribution
// ---------------------------------------------------------------------------
module icache_line_buf
  import icache_refill_pkg::*;
#(
  parameter int LINE_WIDTH = 64,
  parameter int BUS_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_accept,
  input  logic                  i_flush,
  input  logic [BUS_WIDTH-1:0]  i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rlast,
  output logic [LINE_WIDTH-1:0] o_line,
  output logic                  o_last,
  output logic                  o_err,
  output logic                  o_drop
);

  localparam int BEATS = LINE_WIDTH / BUS_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]      r_cnt;
  logic [LINE_WIDTH-1:0] r_line;
  logic                  r_err;
  logic                  r_drop;
  logic                  w_final_cnt;
  logic                  w_beat_err;

  assign w_final_cnt = (r_cnt == LAST_CNT);
  // rlast must coincide exactly with the final beat position.
  assign w_beat_err  = i_accept & ((i_rresp != RESP_OKAY) | (i_rlast != w_final_cnt));

  assign o_last = i_rlast | w_final_cnt;
  assign o_err  = r_err | w_beat_err;
  assign o_drop = r_drop | i_flush;
  assign o_line = r_line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_line <= '0;
      r_err  <= 1'b0;
      r_drop <= 1'b0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_drop <= i_flush;
    end else begin
      if (i_flush) r_drop <= 1'b1;
      if (i_accept) begin
        for (int b = 0; b < BEATS; b++) begin
          if (r_cnt == CNT_W'(b)) r_line[b*BUS_WIDTH +: BUS_WIDTH] <= i_rdata;
        end
        r_cnt <= r_cnt + 1'b1;
        r_err <= o_err;
      end
    end
  end

endmodule

// File: rtl/icache_refill.sv
// ---------------------------------------------------------------------------
// icache_refill
// Miss handler for the 2-way, 64-set instruction cache. Captures the missing
// address and victim way, issues a line-aligned burst read, assembles the
// beats into a line, writes it into the data array and pulses refresh so the
// tag array installs the tag.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   miss, miss_addr, lru, flush   fetch-side request / victim / abandon
//   stallreq                      fetch must hold
//   mem_ar*                       burst read request channel
//   mem_r*                        read data channel
//   data_we/way/index/line        data-array write port
//   refresh                       one-cycle tag install pulse
//   fetch_err                     one-cycle bus error pulse
// ---------------------------------------------------------------------------
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int ADDR_WIDTH   = 64,
  parameter int LINE_WIDTH   = 64,
  parameter int BUS_WIDTH    = 32,
  parameter int OFFSET_WIDTH = OFFSET_W,
  parameter int INDEX_WIDTH  = INDEX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss,
  input  logic [ADDR_WIDTH-1:0]  miss_addr,
  input  logic                   lru,
  input  logic                   flush,
  output logic                   stallreq,
  output logic                   mem_arvalid,
  input  logic                   mem_arready,
  output logic [ADDR_WIDTH-1:0]  mem_araddr,
  output logic [7:0]             mem_arlen,
  input  logic                   mem_rvalid,
  output logic                   mem_rready,
  input  logic [BUS_WIDTH-1:0]   mem_rdata,
  input  logic                   mem_rlast,
  input  logic [1:0]             mem_rresp,
  output logic                   data_we,
  output logic [1:0]             data_way,
  output logic [INDEX_WIDTH-1:0] data_index,
  output logic [LINE_WIDTH-1:0]  data_line,
  output logic                   refresh,
  output logic                   fetch_err
);

  localparam int BEATS = LINE_WIDTH / BUS_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    {{(ADDR_WIDTH-OFFSET_WIDTH){1'b1}}, {OFFSET_WIDTH{1'b0}}};

  refill_state_e         r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_lru;
  logic                  r_fetch_err;
  logic                  w_capture;
  logic                  w_ar_hs;
  logic                  w_accept;
  logic                  w_buf_flush;
  logic                  w_last;
  logic                  w_err;
  logic                  w_drop;
  logic                  w_burst_end;

  assign w_ar_hs     = (r_state == S_REQ) & mem_arready;
  assign w_accept    = (r_state == S_RECV) & mem_rvalid;
  assign w_burst_end = w_accept & w_last;
  // A flush on the handshake cycle cannot cancel the issued burst, so it is
  // recorded as a drop just like a flush during RECV.
  assign w_buf_flush = flush & ((r_state == S_RECV) | w_ar_hs);

  icache_line_buf #(
    .LINE_WIDTH (LINE_WIDTH),
    .BUS_WIDTH  (BUS_WIDTH)
  ) u_line_buf (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_ar_hs),
    .i_accept (w_accept),
    .i_flush  (w_buf_flush),
    .i_rdata  (mem_rdata),
    .i_rresp  (mem_rresp),
    .i_rlast  (mem_rlast),
    .o_line   (data_line),
    .o_last   (w_last),
    .o_err    (w_err),
    .o_drop   (w_drop)
  );

  assign mem_araddr = (r_state == S_REQ) ? (r_addr & ALIGN_MASK) : '0;
  assign mem_arlen  = (r_state == S_REQ) ? 8'(BEATS - 1) : 8'd0;
  assign data_index = r_addr[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
  assign fetch_err  = r_fetch_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_lru       <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state     <= w_next;
      // A flushed fetch is gone, so its bus error is not reported.
      r_fetch_err <= w_burst_end & w_err & ~w_drop;
      if (w_capture) begin
        r_addr <= miss_addr;
        r_lru  <= lru;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_capture   = 1'b0;
    stallreq    = 1'b1;
    mem_arvalid = 1'b0;
    mem_rready  = 1'b0;
    data_we     = 1'b0;
    refresh     = 1'b0;
    data_way    = 2'b00;
    case (r_state)
      S_IDLE: begin
        stallreq = miss & ~flush;
        if (miss & ~flush) begin
          w_capture = 1'b1;
          w_next    = S_REQ;
        end
      end
      S_REQ: begin
        mem_arvalid = 1'b1;
        if (mem_arready)  w_next = S_RECV;
        else if (flush)   w_next = S_IDLE;
      end
      S_RECV: begin
        mem_rready = 1'b1;
        if (w_burst_end) w_next = (w_err | w_drop) ? S_IDLE : S_FILL;
      end
      S_FILL: begin
        data_we  = 1'b1;
        refresh  = 1'b1;
        data_way = r_lru ? 2'b10 : 2'b01;
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        stallreq = 1'b0;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
